mult_div_seq: RTL and testbench

Multi-cycle signed multiply/divide sequencer that owns the architectural Hi and Lo registers of the multicycle CPU. It fills the Div/Mult/Hi/Lo slot of the datapath. Its inputs are RegA/RegB and a start pulse from `controladora`. It runs a 32-iteration shift-add (mult) or restoring (div) loop, then returns a `done` pulse and updated Hi/Lo to the MemtoReg mux (mfhi/mflo).

---
 rtl/mult_div_pkg.sv | 17 +
 rtl/abs_neg.sv | 12 +
 rtl/mult_div_seq.sv | 130 +++++++++++++
 tb/tb_mult_div_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, op select, loop length.
package mult_div_pkg;

    localparam int ITER = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/abs_neg.sv
// Conditional two's-complement negate, used for divide operand magnitudes and result sign fix-up.
module abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? -val : val;

endmodule

// File: rtl/mult_div_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) sequencer owning Hi/Lo.
// Hi/Lo update on the edge entering DONE; a divide by zero leaves them untouched.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             stateReg, stateNext;
    logic [5:0]         iterReg;
    logic [2*WIDTH:0]   prodReg, prodNext;
    logic [WIDTH-1:0]   mcandReg, remReg, quoReg, divisorReg;
    logic [WIDTH-1:0]   hiReg, loReg;
    logic               signAReg, signBReg, divZeroReg;
    logic [WIDTH:0]     boothHi, remShift, remDiff;
    logic [WIDTH-1:0]   remNext, quoNext;
    logic [WIDTH-1:0]   aMag, bMag, quoFix, remFix;
    logic               iterLast;

    abs_neg #(.WIDTH(WIDTH)) absA (.val(a),      .neg(a[WIDTH-1]),          .result(aMag));
    abs_neg #(.WIDTH(WIDTH)) absB (.val(b),      .neg(b[WIDTH-1]),          .result(bMag));
    abs_neg #(.WIDTH(WIDTH)) fixQ (.val(quoReg), .neg(signAReg ^ signBReg), .result(quoFix));
    abs_neg #(.WIDTH(WIDTH)) fixR (.val(remReg), .neg(signAReg),            .result(remFix));

    assign iterLast = (iterReg == 6'(ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateReg <= IDLE;
        else     stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (start) begin
                if (op == OP_MULT)         stateNext = MULT;
                else if (b == '0)          stateNext = DONE;
                else                       stateNext = DIV;
            end
            MULT:    if (iterLast) stateNext = DONE;
            DIV:     if (iterLast) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Booth step: the add/sub is one bit wider than the upper half so a*b with
    // a = most-negative cannot overflow before the arithmetic shift.
    always_comb begin
        boothHi = {prodReg[2*WIDTH], prodReg[2*WIDTH:WIDTH+1]};
        case (prodReg[1:0])
            2'b01:   boothHi = boothHi + {mcandReg[WIDTH-1], mcandReg};
            2'b10:   boothHi = boothHi - {mcandReg[WIDTH-1], mcandReg};
            default: boothHi = boothHi;
        endcase
        prodNext = {boothHi, prodReg[WIDTH:1]};
    end

    always_comb begin
        remShift = {remReg, quoReg[WIDTH-1]};
        remDiff  = remShift - {1'b0, divisorReg};
        remNext  = remDiff[WIDTH] ? remShift[WIDTH-1:0] : remDiff[WIDTH-1:0];
        quoNext  = {quoReg[WIDTH-2:0], ~remDiff[WIDTH]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iterReg    <= '0;
            prodReg    <= '0;
            mcandReg   <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            signAReg   <= 1'b0;
            signBReg   <= 1'b0;
            divZeroReg <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
        end else begin
            case (stateReg)
                IDLE: if (start) begin
                    iterReg    <= '0;
                    mcandReg   <= a;
                    prodReg    <= {{WIDTH{1'b0}}, b, 1'b0};
                    remReg     <= '0;
                    quoReg     <= aMag;
                    divisorReg <= bMag;
                    signAReg   <= a[WIDTH-1];
                    signBReg   <= b[WIDTH-1];
                    divZeroReg <= (op == OP_DIV) && (b == '0);
                end
                MULT: begin
                    prodReg <= prodNext;
                    iterReg <= iterReg + 6'd1;
                    if (iterLast) {hiReg, loReg} <= prodNext[2*WIDTH:1];
                end
                DIV: begin
                    remReg  <= remNext;
                    quoReg  <= quoNext;
                    iterReg <= iterReg + 6'd1;
                end
                FIX: begin
                    hiReg <= remFix;
                    loReg <= quoFix;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (stateReg != IDLE);
    assign done     = (stateReg == DONE);
    assign div_zero = (stateReg == DONE) && divZeroReg;
    assign hi       = hiReg;
    assign lo       = loReg;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: stimulus pushes expected Hi/Lo/flag/latency,
// an independent negedge monitor pops and compares whenever done is presented.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          c0;
    } exp_t;

    exp_t        sbQ[$];
    int          cycleCnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // ---------------- monitor / checker ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cycleCnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbQ.delete();
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_divzero", 32'(div_zero), 32'd0);
            check("rst_hi", hi, 32'd0);
            check("rst_lo", lo, 32'd0);
        end else begin
            check("busy", 32'(busy), 32'(sbQ.size() != 0));
            if (sbQ.size() != 0 && cycleCnt > sbQ[0].c0 + 40) begin
                check("timeout_done", 32'(done), 32'd1);
                void'(sbQ.pop_front());
            end else if (done) begin
                if (sbQ.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("div_zero", 32'(div_zero), 32'(e.dz));
                    check("latency", 32'(cycleCnt - e.c0 + 1), 32'(e.lat));
                    $display("op done: hi=%h lo=%h dz=%0d lat=%0d", hi, lo, div_zero, cycleCnt - e.c0 + 1);
                end
            end else begin
                check("divzero_without_done", 32'(div_zero), 32'd0);
            end
        end
    end

    // ---------------- reference model + driver ----------------
    task automatic pushExpected(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint p, q, r;
        if (o == 1'b0) begin
            p    = longint'($signed(x)) * longint'($signed(y));
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.lat = 33;
        end else if (y == 32'd0) begin
            e.hi = modelHi;
            e.lo = modelLo;
            e.dz = 1'b1;
            e.lat = 1;
        end else begin
            q    = longint'($signed(x)) / longint'($signed(y));
            r    = longint'($signed(x)) % longint'($signed(y));
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
            e.lat = 34;
        end
        e.c0 = cycleCnt;
        modelHi = e.hi;
        modelLo = e.lo;
        sbQ.push_back(e);
    endtask

    // Entered just after a posedge with the DUT idle; returns in the same situation.
    task automatic runOp(input logic o, input logic [31:0] x, input logic [31:0] y, input bit midStart);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        pushExpected(o, x, y);
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (midStart && k == 5) begin
                start = 1'b1; op = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        // start raised during DONE must be ignored
        start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom | 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        logic        ro;
        logic [31:0] ra, rb;

        #32 rst = 1'b0;
        @(posedge clk); #1;

        runOp(1'b0, 32'd7, 32'hFFFFFFFD, 1'b1);
        runOp(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        runOp(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
        runOp(1'b1, 32'h56781234, 32'h00010000, 1'b0);
        runOp(1'b1, 32'd5, 32'd0, 1'b0);
        runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        runOp(1'b0, 32'h80000000, 32'h80000000, 1'b0);

        // reset in the middle of a mult
        start = 1'b1; op = 1'b0; a = 32'd1234; b = 32'd5678;
        @(posedge clk); #1;
        pushExpected(1'b0, 32'd1234, 32'd5678);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        modelHi = '0;
        modelLo = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        runOp(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 20));
                4: ra = 32'($urandom_range(0, 100)) - 32'd50;
                default: ;
            endcase
            runOp(ro, ra, rb, n % 5 == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
